// File: rtl/symbol_round_ctrl_if.sv
// Handshake and display bundle between the round controller and its surroundings.
// The master drives tick/start/answer inputs; the slave is the round controller.
interface symbol_round_ctrl_if;
  logic       tick1Hz;
  logic       startBtn;
  logic       postSig;
  logic       stopCount;
  logic [7:0] userCount;
  logic       answerSig;
  logic       busy;
  logic [7:0] symbolSeg;
  logic [7:0] resultSeg0;
  logic [7:0] resultSeg1;
  logic       winLed;
  logic       lossLed;
  logic [7:0] scoreSeg0;
  logic [7:0] scoreSeg1;

  modport master (
    output tick1Hz, startBtn, postSig, stopCount, userCount,
    input  answerSig, busy, symbolSeg, resultSeg0, resultSeg1, winLed, lossLed,
           scoreSeg0, scoreSeg1
  );

  modport slave (
    input  tick1Hz, startBtn, postSig, stopCount, userCount,
    output answerSig, busy, symbolSeg, resultSeg0, resultSeg1, winLed, lossLed,
           scoreSeg0, scoreSeg1
  );
endinterface

// File: rtl/symbol_round_ctrl.sv
// Symbol-counting game round controller: show symbols, run the answer period, score.
// Optional wins tally enabled by defining SYMROUND_SCORE_TALLY_EN.
module symbol_round_ctrl #(
  parameter int unsigned NUM_SYMBOLS    = 10,
  parameter int unsigned ANSWER_TIMEOUT = 8,
  parameter int unsigned RESULT_SECS    = 3,
  parameter int unsigned TARGET_SYM     = 0
) (
  input logic                Clk100M,
  input logic                resetN,
  symbol_round_ctrl_if.slave bus
);

  localparam int unsigned TimerW   = 16;
  localparam logic [7:0]  SegBlank = 8'hFF;

  typedef enum logic [1:0] {StIdle, StShow, StAnswer, StScore} state_e;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hD8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  state_e              state_q, state_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic                start_prev_q;
  logic [6:0]          sym_idx_q, sym_idx_d;
  logic [6:0]          target_cnt_q, target_cnt_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                answer_q, answer_d;
  logic [7:0]          sym_seg_q, sym_seg_d;
  logic [7:0]          res_seg0_q, res_seg0_d;
  logic [7:0]          res_seg1_q, res_seg1_d;
  logic                win_q, win_d;
  logic                loss_q, loss_d;
  logic                start_edge;
  logic                answer_evt;
  logic                enter_score;
  logic                score_win;

  assign start_edge = bus.startBtn & ~start_prev_q;
  assign answer_evt = bus.postSig | bus.stopCount;
  // Galois form, taps x^8+x^6+x^5+x^4+1; a nonzero seed never reaches zero.
  assign lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ 8'hB8) : (lfsr_q >> 1);

  always_comb begin
    state_d      = state_q;
    sym_idx_d    = sym_idx_q;
    target_cnt_d = target_cnt_q;
    timer_d      = timer_q;
    answer_d     = 1'b0;
    sym_seg_d    = sym_seg_q;
    res_seg0_d   = res_seg0_q;
    res_seg1_d   = res_seg1_q;
    win_d        = win_q;
    loss_d       = loss_q;
    enter_score  = 1'b0;
    score_win    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          target_cnt_d = '0;
          sym_idx_d    = '0;
          sym_seg_d    = SegBlank;
          res_seg0_d   = SegBlank;
          res_seg1_d   = SegBlank;
          win_d        = 1'b0;
          loss_d       = 1'b0;
          state_d      = StShow;
        end
      end
      StShow: begin
        if (bus.tick1Hz) begin
          if (sym_idx_q == 7'(NUM_SYMBOLS)) begin
            sym_seg_d = SegBlank;
            timer_d   = '0;
            answer_d  = 1'b1;
            state_d   = StAnswer;
          end else begin
            sym_seg_d = seg7({2'b00, lfsr_q[1:0]});
            sym_idx_d = sym_idx_q + 7'd1;
            if (lfsr_q[1:0] == 2'(TARGET_SYM) && target_cnt_q != 7'd99) begin
              target_cnt_d = target_cnt_q + 7'd1;
            end
          end
        end
      end
      StAnswer: begin
        // An answer event beats a coincident tick, so it can never time out.
        if (answer_evt) begin
          enter_score = 1'b1;
          score_win   = (bus.userCount == {1'b0, target_cnt_q});
        end else if (bus.tick1Hz) begin
          if (timer_q == TimerW'(ANSWER_TIMEOUT - 1)) begin
            enter_score = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      StScore: begin
        if (bus.tick1Hz) begin
          if (timer_q == TimerW'(RESULT_SECS - 1)) begin
            state_d = StIdle;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_score) begin
      state_d    = StScore;
      timer_d    = '0;
      win_d      = score_win;
      loss_d     = ~score_win;
      res_seg0_d = seg7(4'(target_cnt_q / 7'd10));
      res_seg1_d = seg7(4'(target_cnt_q % 7'd10));
    end
  end

  // start_prev resets high so a button held through reset needs a fresh press.
  always_ff @(posedge Clk100M or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StIdle;
      lfsr_q       <= 8'hA5;
      start_prev_q <= 1'b1;
      sym_idx_q    <= '0;
      target_cnt_q <= '0;
      timer_q      <= '0;
      answer_q     <= 1'b0;
      sym_seg_q    <= SegBlank;
      res_seg0_q   <= SegBlank;
      res_seg1_q   <= SegBlank;
      win_q        <= 1'b0;
      loss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      start_prev_q <= bus.startBtn;
      sym_idx_q    <= sym_idx_d;
      target_cnt_q <= target_cnt_d;
      timer_q      <= timer_d;
      answer_q     <= answer_d;
      sym_seg_q    <= sym_seg_d;
      res_seg0_q   <= res_seg0_d;
      res_seg1_q   <= res_seg1_d;
      win_q        <= win_d;
      loss_q       <= loss_d;
    end
  end

  assign bus.answerSig  = answer_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.symbolSeg  = sym_seg_q;
  assign bus.resultSeg0 = res_seg0_q;
  assign bus.resultSeg1 = res_seg1_q;
  assign bus.winLed     = win_q;
  assign bus.lossLed    = loss_q;

`ifdef SYMROUND_SCORE_TALLY_EN
  logic [6:0] wins_q, wins_d;
  logic       score_first_q;
  logic [7:0] score_seg0_q, score_seg0_d;
  logic [7:0] score_seg1_q, score_seg1_d;

  // Display follows the counter one cycle after SCORE entry.
  always_comb begin
    wins_d       = wins_q;
    score_seg0_d = score_seg0_q;
    score_seg1_d = score_seg1_q;
    if (enter_score && score_win && wins_q != 7'd99) begin
      wins_d = wins_q + 7'd1;
    end
    if (score_first_q) begin
      score_seg0_d = seg7(4'(wins_q / 7'd10));
      score_seg1_d = seg7(4'(wins_q % 7'd10));
    end
  end

  always_ff @(posedge Clk100M or negedge resetN) begin
    if (!resetN) begin
      wins_q        <= '0;
      score_first_q <= 1'b0;
      score_seg0_q  <= SegBlank;
      score_seg1_q  <= SegBlank;
    end else begin
      wins_q        <= wins_d;
      score_first_q <= enter_score;
      score_seg0_q  <= score_seg0_d;
      score_seg1_q  <= score_seg1_d;
    end
  end

  assign bus.scoreSeg0 = score_seg0_q;
  assign bus.scoreSeg1 = score_seg1_q;
`else
  assign bus.scoreSeg0 = SegBlank;
  assign bus.scoreSeg1 = SegBlank;
`endif

endmodule

// File: tb/tb_symbol_round_ctrl.sv
// Randomized self-checking bench for symbol_round_ctrl against a behavioural round model.
module tb_symbol_round_ctrl;
  localparam int unsigned NumSym    = 4;
  localparam int unsigned AnsTo     = 8;
  localparam int unsigned ResSecs   = 3;
  localparam int unsigned TargetSym = 0;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  symbol_round_ctrl_if bus ();

  symbol_round_ctrl #(
    .NUM_SYMBOLS   (NumSym),
    .ANSWER_TIMEOUT(AnsTo),
    .RESULT_SECS   (ResSecs),
    .TARGET_SYM    (TargetSym)
  ) dut (
    .Clk100M(clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int m_wins   = 0;

  // Reference symbol source: the specified LFSR, stepped once per clock.
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge resetN) begin
    if (!resetN) m_lfsr <= 8'hA5;
    else         m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
  end

  function automatic logic [7:0] seg_of(input int d);
    logic [7:0] tbl [10];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hD8, 8'h80, 8'h90};
    return tbl[d];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_tick(output logic [1:0] sym);
    bus.tick1Hz = 1'b1;
    sym = m_lfsr[1:0];
    step();
    bus.tick1Hz = 1'b0;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    idle(3);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.answerSig !== 1'b0) begin failures++; $display("FAIL reset_answer got=%b exp=0", bus.answerSig); end
    checks++; if ({bus.winLed, bus.lossLed} !== 2'b00) begin failures++; $display("FAIL reset_leds got=%b exp=00", {bus.winLed, bus.lossLed}); end
    checks++; if ({bus.symbolSeg, bus.resultSeg0, bus.resultSeg1} !== 24'hFFFFFF) begin failures++; $display("FAIL reset_segs got=%h exp=ffffff", {bus.symbolSeg, bus.resultSeg0, bus.resultSeg1}); end
    checks++; if ({bus.scoreSeg0, bus.scoreSeg1} !== 16'hFFFF) begin failures++; $display("FAIL reset_score got=%h exp=ffff", {bus.scoreSeg0, bus.scoreSeg1}); end
    #3 resetN = 1'b1;
    idle(3);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
  endtask

  // Starts a round and plays the full symbol phase; returns the model's target count.
  task automatic play_show(output int cnt);
    logic [1:0] sym;
    cnt = 0;
    bus.startBtn = 1'b1;
    step();
    bus.startBtn = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%b exp=1", bus.busy); end
    checks++; if ({bus.winLed, bus.lossLed, bus.resultSeg0} !== 10'h0FF) begin failures++; $display("FAIL start_clear got=%h exp=0ff", {bus.winLed, bus.lossLed, bus.resultSeg0}); end
    for (int i = 0; i < int'(NumSym); i++) begin
      idle($urandom_range(0, 4));
      if (i == 1) begin
        bus.postSig = 1'b1;
        bus.userCount = 8'(cnt);
        step();
        bus.postSig = 1'b0;
        checks++; if ({bus.winLed, bus.lossLed} !== 2'b00) begin failures++; $display("FAIL stray_post got=%b exp=00", {bus.winLed, bus.lossLed}); end
        bus.startBtn = 1'b1;
        step();
        bus.startBtn = 1'b0;
      end
      pulse_tick(sym);
      if (int'(sym) == int'(TargetSym)) cnt++;
      checks++; if (bus.symbolSeg !== seg_of(int'(sym))) begin failures++; $display("FAIL show_sym%0d got=%h exp=%h", i, bus.symbolSeg, seg_of(int'(sym))); end
      checks++; if ({bus.answerSig, bus.busy} !== 2'b01) begin failures++; $display("FAIL show_ctl%0d got=%b exp=01", i, {bus.answerSig, bus.busy}); end
    end
    idle($urandom_range(0, 4));
    pulse_tick(sym);
    checks++; if (bus.symbolSeg !== 8'hFF) begin failures++; $display("FAIL show_blank got=%h exp=ff", bus.symbolSeg); end
    checks++; if (bus.answerSig !== 1'b1) begin failures++; $display("FAIL answer_pulse got=%b exp=1", bus.answerSig); end
    step();
    checks++; if (bus.answerSig !== 1'b0) begin failures++; $display("FAIL answer_once got=%b exp=0", bus.answerSig); end
  endtask

  task automatic do_answer(input int cnt, input logic [7:0] user, input bit use_stop,
                           input int pre_ticks, input bit with_tick, output bit exp_win);
    logic [1:0] sym;
    for (int i = 0; i < pre_ticks; i++) begin
      idle($urandom_range(0, 2));
      pulse_tick(sym);
      checks++; if ({bus.busy, bus.winLed, bus.lossLed} !== 3'b100) begin failures++; $display("FAIL answer_wait%0d got=%b exp=100", i, {bus.busy, bus.winLed, bus.lossLed}); end
    end
    idle($urandom_range(0, 2));
    if (use_stop) bus.stopCount = 1'b1;
    else          bus.postSig = 1'b1;
    bus.tick1Hz = with_tick;
    bus.userCount = user;
    step();
    bus.stopCount = 1'b0;
    bus.postSig = 1'b0;
    bus.tick1Hz = 1'b0;
    bus.userCount = 8'($urandom);
    exp_win = (int'(user) == cnt);
    if (exp_win && m_wins < 99) m_wins++;
    checks++; if ({bus.winLed, bus.lossLed} !== {exp_win, !exp_win}) begin failures++; $display("FAIL result_leds got=%b exp=%b", {bus.winLed, bus.lossLed}, {exp_win, !exp_win}); end
    checks++; if (bus.resultSeg0 !== seg_of(cnt / 10)) begin failures++; $display("FAIL result_tens got=%h exp=%h", bus.resultSeg0, seg_of(cnt / 10)); end
    checks++; if (bus.resultSeg1 !== seg_of(cnt % 10)) begin failures++; $display("FAIL result_ones got=%h exp=%h", bus.resultSeg1, seg_of(cnt % 10)); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL score_busy got=%b exp=1", bus.busy); end
  endtask

  task automatic do_score(input bit exp_win);
    logic [1:0] sym;
    logic [7:0] exp_s0, exp_s1;
    for (int i = 0; i < int'(ResSecs); i++) begin
      idle($urandom_range(0, 3));
      pulse_tick(sym);
      checks++; if (bus.busy !== (i != int'(ResSecs) - 1)) begin failures++; $display("FAIL score_len%0d got=%b exp=%b", i, bus.busy, (i != int'(ResSecs) - 1)); end
    end
    idle(2);
    checks++; if ({bus.busy, bus.winLed, bus.lossLed} !== {1'b0, exp_win, !exp_win}) begin failures++; $display("FAIL persist got=%b exp=%b", {bus.busy, bus.winLed, bus.lossLed}, {1'b0, exp_win, !exp_win}); end
`ifdef SYMROUND_SCORE_TALLY_EN
    exp_s0 = seg_of(m_wins / 10);
    exp_s1 = seg_of(m_wins % 10);
`else
    exp_s0 = 8'hFF;
    exp_s1 = 8'hFF;
`endif
    checks++; if ({bus.scoreSeg0, bus.scoreSeg1} !== {exp_s0, exp_s1}) begin failures++; $display("FAIL tally got=%h exp=%h", {bus.scoreSeg0, bus.scoreSeg1}, {exp_s0, exp_s1}); end
  endtask

  task automatic test_win();
    int cnt; bit w;
    play_show(cnt);
    do_answer(cnt, 8'(cnt), 1'b0, $urandom_range(0, 2), 1'b0, w);
    do_score(w);
  endtask

  task automatic test_loss_stop();
    int cnt; bit w; logic [7:0] user;
    play_show(cnt);
    user = ($urandom_range(0, 1) == 1) ? 8'(100 + $urandom_range(0, 155))
                                       : 8'(cnt + 1 + int'($urandom_range(0, 3)));
    do_answer(cnt, user, 1'b1, $urandom_range(0, 2), 1'b0, w);
    do_score(w);
  endtask

  task automatic test_timeout();
    int cnt; logic [1:0] sym;
    play_show(cnt);
    for (int i = 0; i < int'(AnsTo); i++) begin
      idle($urandom_range(0, 2));
      pulse_tick(sym);
      if (i < int'(AnsTo) - 1) begin
        checks++; if ({bus.busy, bus.lossLed} !== 2'b10) begin failures++; $display("FAIL to_wait%0d got=%b exp=10", i, {bus.busy, bus.lossLed}); end
      end
    end
    checks++; if ({bus.winLed, bus.lossLed} !== 2'b01) begin failures++; $display("FAIL to_loss got=%b exp=01", {bus.winLed, bus.lossLed}); end
    checks++; if (bus.resultSeg1 !== seg_of(cnt % 10)) begin failures++; $display("FAIL to_ones got=%h exp=%h", bus.resultSeg1, seg_of(cnt % 10)); end
    bus.postSig = 1'b1;
    bus.userCount = 8'(cnt);
    step();
    bus.postSig = 1'b0;
    checks++; if ({bus.winLed, bus.lossLed} !== 2'b01) begin failures++; $display("FAIL late_post got=%b exp=01", {bus.winLed, bus.lossLed}); end
    do_score(1'b0);
  endtask

  // Final timeout tick coincides with postSig: the answer must win.
  task automatic test_tick_post_same();
    int cnt; bit w;
    play_show(cnt);
    do_answer(cnt, 8'(cnt), $urandom_range(0, 1) == 1, int'(AnsTo) - 1, 1'b1, w);
    do_score(w);
  endtask

  task automatic test_reset_mid();
    logic [1:0] sym;
    bus.startBtn = 1'b1;
    step();
    bus.startBtn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idle($urandom_range(0, 3));
      pulse_tick(sym);
    end
    #2 resetN = 1'b0;
    bus.startBtn = 1'b1;
    #1;
    checks++; if ({bus.busy, bus.answerSig, bus.winLed, bus.lossLed} !== 4'b0000) begin failures++; $display("FAIL midrst_ctl got=%b exp=0000", {bus.busy, bus.answerSig, bus.winLed, bus.lossLed}); end
    checks++; if ({bus.symbolSeg, bus.resultSeg0, bus.resultSeg1} !== 24'hFFFFFF) begin failures++; $display("FAIL midrst_segs got=%h exp=ffffff", {bus.symbolSeg, bus.resultSeg0, bus.resultSeg1}); end
    checks++; if ({bus.scoreSeg0, bus.scoreSeg1} !== 16'hFFFF) begin failures++; $display("FAIL midrst_score got=%h exp=ffff", {bus.scoreSeg0, bus.scoreSeg1}); end
    m_wins = 0;
    idle(2);
    #3 resetN = 1'b1;
    idle(2);
    pulse_tick(sym);
    idle(2);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL held_start got=%b exp=0", bus.busy); end
    bus.startBtn = 1'b0;
    step();
    bus.startBtn = 1'b1;
    step();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL restart got=%b exp=1", bus.busy); end
    resetN = 1'b0;
    bus.startBtn = 1'b0;
    idle(2);
    #3 resetN = 1'b1;
    idle(2);
  endtask

  task automatic test_tally();
    int cnt; bit w;
    for (int r = 0; r < 2; r++) begin
      play_show(cnt);
      do_answer(cnt, 8'(cnt), $urandom_range(0, 1) == 1, $urandom_range(0, 3), 1'b0, w);
      do_score(w);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.tick1Hz   = 1'b0;
    bus.startBtn  = 1'b0;
    bus.postSig   = 1'b0;
    bus.stopCount = 1'b0;
    bus.userCount = 8'h00;
    test_reset();
    test_win();
    test_loss_stop();
    test_timeout();
    test_tick_post_same();
    test_reset_mid();
    test_tally();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
